// File: rtl/pc_seq_ctrl_if.sv
// rtl/pc_seq_ctrl_if.sv - fetch/execute/debug signal bundle for the Y86-64 sequencing controller
// Optional breakpoint signals are present only when PC_BREAK_EN is defined.
interface pc_seq_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             run_i;
  logic             step_i;
  logic             stop_i;
  logic [3:0]       icode_i;
  logic             cnd_i;
  logic [63:0]      valC_i;
  logic [63:0]      valP_i;
  logic [63:0]      valM_i;
  logic             instr_valid_i;
  logic             imem_error_i;
  logic             dmem_error_i;
  logic [63:0]      PC_o;
  logic             commit_o;
  logic [2:0]       stat_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] instr_cnt_o;
`ifdef PC_BREAK_EN
  logic             bkpt_en_i;
  logic [63:0]      bkpt_addr_i;
  logic             bkpt_hit_o;

  modport slave (
    input  run_i, step_i, stop_i, icode_i, cnd_i, valC_i, valP_i, valM_i,
           instr_valid_i, imem_error_i, dmem_error_i, bkpt_en_i, bkpt_addr_i,
    output PC_o, commit_o, stat_o, state_o, instr_cnt_o, bkpt_hit_o
  );
  modport master (
    output run_i, step_i, stop_i, icode_i, cnd_i, valC_i, valP_i, valM_i,
           instr_valid_i, imem_error_i, dmem_error_i, bkpt_en_i, bkpt_addr_i,
    input  PC_o, commit_o, stat_o, state_o, instr_cnt_o, bkpt_hit_o
  );
`else
  modport slave (
    input  run_i, step_i, stop_i, icode_i, cnd_i, valC_i, valP_i, valM_i,
           instr_valid_i, imem_error_i, dmem_error_i,
    output PC_o, commit_o, stat_o, state_o, instr_cnt_o
  );
  modport master (
    output run_i, step_i, stop_i, icode_i, cnd_i, valC_i, valP_i, valM_i,
           instr_valid_i, imem_error_i, dmem_error_i,
    input  PC_o, commit_o, stat_o, state_o, instr_cnt_o
  );
`endif
endinterface

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - PC register, next-PC select and run/step/stop commit gating for Y86-64
// Optional PC breakpoint enabled by defining PC_BREAK_EN.
module pc_seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  pc_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  state_t           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       exc_stat;
  logic [63:0]      next_pc;
  logic             bkpt_trig;
  logic             active;
  logic             commit;

  always_comb begin
    exc_stat = STAT_AOK;
    if (bus.imem_error_i || bus.dmem_error_i) begin
      exc_stat = STAT_ADR;
    end else if (!bus.instr_valid_i) begin
      exc_stat = STAT_INS;
    end else if (bus.icode_i == 4'h0) begin
      exc_stat = STAT_HLT;
    end
  end

  always_comb begin
    next_pc = bus.valP_i;
    case (bus.icode_i)
      4'h8:    next_pc = bus.valC_i;
      4'h7:    next_pc = bus.cnd_i ? bus.valC_i : bus.valP_i;
      4'h9:    next_pc = bus.valM_i;
      default: next_pc = bus.valP_i;
    endcase
  end

`ifdef PC_BREAK_EN
  logic bkpt_hit_q, bkpt_hit_d;
  assign bkpt_trig = (state_q == S_RUN) && !bus.stop_i && bus.bkpt_en_i
                     && (pc_q == bus.bkpt_addr_i);
`else
  assign bkpt_trig = 1'b0;
`endif

  // A breakpoint hit suppresses the instruction exactly like a stop request.
  assign active = ((state_q == S_RUN) && !bus.stop_i && !bkpt_trig) || (state_q == S_STEP);
  assign commit = rst_n_i && active && (exc_stat == STAT_AOK);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run_i) begin
          state_d = S_RUN;
        end else if (bus.step_i) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (bus.stop_i || bkpt_trig) begin
          state_d = S_IDLE;
        end else if (exc_stat != STAT_AOK) begin
          state_d = S_HALT;
          stat_d  = exc_stat;
        end
      end
      S_STEP: begin
        if (exc_stat != STAT_AOK) begin
          state_d = S_HALT;
          stat_d  = exc_stat;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_HALT;
    endcase
    if (commit) begin
      pc_d  = next_pc;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_BREAK_EN
  // Sticky until the debugger resumes by leaving IDLE.
  always_comb begin
    bkpt_hit_d = bkpt_hit_q;
    if (bkpt_trig) begin
      bkpt_hit_d = 1'b1;
    end else if ((state_q == S_IDLE) && (bus.run_i || bus.step_i)) begin
      bkpt_hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bkpt_hit_q <= 1'b0;
    end else begin
      bkpt_hit_q <= bkpt_hit_d;
    end
  end

  assign bus.bkpt_hit_o = bkpt_hit_q;
`endif

  assign bus.PC_o        = pc_q;
  assign bus.commit_o    = commit;
  assign bus.stat_o      = stat_q;
  assign bus.state_o     = state_q;
  assign bus.instr_cnt_o = cnt_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - scoreboard bench for pc_seq_ctrl with a behavioural Y86 sequencing model
// Breakpoint stimulus is included when PC_BREAK_EN is defined.
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_seq_ctrl_if #(.CNT_W(32)) bus ();

  pc_seq_ctrl #(.RESET_PC(64'h0), .CNT_W(32)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        rst, run, step, stop, cnd, valid, ie, de, ben;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM, baddr;
  } stim_t;

  typedef struct {
    logic        commit, hit;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [1:0]  state;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model: mode 0 idle, 1 run, 2 step, 3 halted.
  int          m_mode = 0;
  logic [63:0] m_pc   = 64'h0;
  int          m_stat = 1;
  logic [31:0] m_cnt  = 32'h0;
  bit          m_hit  = 1'b0;

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 1'b1, run: 1'b0, step: 1'b0, stop: 1'b0, cnd: 1'b0, valid: 1'b1,
          ie: 1'b0, de: 1'b0, ben: 1'b0, icode: 4'h1,
          valC: 64'h0, valP: 64'h0, valM: 64'h0, baddr: 64'h0};
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input stim_t s);
    exp_t        e;
    int          fault;
    bit          brk, exec;
    logic [63:0] target;
    rst_n             = s.rst;
    bus.run_i         = s.run;
    bus.step_i        = s.step;
    bus.stop_i        = s.stop;
    bus.icode_i       = s.icode;
    bus.cnd_i         = s.cnd;
    bus.valC_i        = s.valC;
    bus.valP_i        = s.valP;
    bus.valM_i        = s.valM;
    bus.instr_valid_i = s.valid;
    bus.imem_error_i  = s.ie;
    bus.dmem_error_i  = s.de;
`ifdef PC_BREAK_EN
    bus.bkpt_en_i     = s.ben;
    bus.bkpt_addr_i   = s.baddr;
    brk = (m_mode == 1) && !s.stop && s.ben && (m_pc == s.baddr);
`else
    brk = 1'b0;
`endif
    if (s.ie || s.de)     fault = 3;
    else if (!s.valid)    fault = 4;
    else if (s.icode == 0) fault = 2;
    else                  fault = 1;
    exec = ((m_mode == 1 && !s.stop && !brk) || m_mode == 2) && s.rst;
    if (s.icode == 4'h8 || (s.icode == 4'h7 && s.cnd)) target = s.valC;
    else if (s.icode == 4'h9) target = s.valM;
    else target = s.valP;

    e.commit = exec && (fault == 1);
    e.pc     = m_pc;
    e.stat   = 3'(m_stat);
    e.state  = 2'(m_mode);
    e.cnt    = m_cnt;
    e.hit    = m_hit;
    exp_q.push_back(e);

    @(posedge clk);
    if (!s.rst) begin
      m_mode = 0; m_pc = 64'h0; m_stat = 1; m_cnt = 0; m_hit = 1'b0;
    end else if (m_mode == 0) begin
      if (s.run || s.step) begin
        m_mode = s.run ? 1 : 2;
        m_hit  = 1'b0;
      end
    end else if (m_mode != 3) begin
      if (brk) begin
        m_mode = 0;
        m_hit  = 1'b1;
      end else if (m_mode == 1 && s.stop) begin
        m_mode = 0;
      end else if (fault != 1) begin
        m_mode = 3;
        m_stat = fault;
      end else begin
        m_pc   = target;
        m_cnt  = m_cnt + 1;
        if (m_mode == 2) m_mode = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("commit_o", 64'(bus.commit_o), 64'(e.commit));
        chk("PC_o", bus.PC_o, e.pc);
        chk("stat_o", 64'(bus.stat_o), 64'(e.stat));
        chk("state_o", 64'(bus.state_o), 64'(e.state));
        chk("instr_cnt_o", 64'(bus.instr_cnt_o), 64'(e.cnt));
`ifdef PC_BREAK_EN
        chk("bkpt_hit_o", 64'(bus.bkpt_hit_o), 64'(e.hit));
`endif
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    tick_init();
    // irmovq; halt from reset
    s = nop(); s.run = 1; s.icode = 4'h3; s.valP = 64'hA; tick(s);
    tick(s);
    s = nop(); s.icode = 4'h0; s.valP = 64'hB; tick(s);
    s.run = 1; s.step = 1; tick(s); tick(s);
    s = nop(); s.rst = 0; tick(s);
    // single step through a taken jump
    s = nop(); s.step = 1; s.icode = 4'h7; s.cnd = 1; s.valC = 64'h27; s.valP = 64'h9;
    tick(s); tick(s);
    s = nop(); tick(s);
    // run: ret, not-taken jump, call to 0x400, then fetch fault there
    s = nop(); s.run = 1; tick(s);
    s = nop(); s.icode = 4'h9; s.valM = 64'h7D; s.valP = 64'h28; tick(s);
    s = nop(); s.icode = 4'h7; s.cnd = 0; s.valC = 64'h99; s.valP = 64'h31; tick(s);
    s = nop(); s.stop = 1; s.run = 1; s.icode = 4'h3; s.valP = 64'h3B; tick(s);
    s = nop(); s.run = 1; s.step = 1; tick(s);
    s = nop(); s.icode = 4'h8; s.valC = 64'h400; s.valP = 64'h3A; tick(s);
    s = nop(); s.ie = 1; s.valP = 64'h40A; tick(s);
    s = nop(); s.run = 1; s.step = 1; s.valP = 64'h500; tick(s); tick(s);
    s = nop(); s.rst = 0; tick(s);
    s = nop(); tick(s);
`ifdef PC_BREAK_EN
    s = nop(); s.run = 1; s.ben = 1; s.baddr = 64'h27;
    s.icode = 4'h7; s.cnd = 1; s.valC = 64'h27; tick(s); tick(s);
    s.icode = 4'h3; s.valP = 64'h31; tick(s);
    s.run = 0; tick(s);
    s.step = 1; tick(s); tick(s);
    s.step = 0; tick(s);
`endif
    for (int i = 0; i < 3000; i++) begin
      s = nop();
      s.rst   = !(($urandom_range(0, 99) == 0) || (m_mode == 3 && $urandom_range(0, 7) == 0));
      s.run   = ($urandom_range(0, 3) == 0);
      s.step  = ($urandom_range(0, 3) == 0);
      s.stop  = ($urandom_range(0, 7) == 0);
      s.icode = 4'($urandom_range(0, 11));
      if (s.icode == 4'h0 && $urandom_range(0, 7) != 0) s.icode = 4'h1;
      s.cnd   = 1'($urandom_range(0, 1));
      s.valid = ($urandom_range(0, 40) != 0);
      s.ie    = ($urandom_range(0, 60) == 0);
      s.de    = ($urandom_range(0, 60) == 0);
      s.valC  = {$urandom, $urandom};
      s.valP  = {$urandom, $urandom};
      s.valM  = {$urandom, $urandom};
      s.ben   = ($urandom_range(0, 1) == 1);
      s.baddr = ($urandom_range(0, 3) == 0) ? m_pc : {$urandom, $urandom};
      tick(s);
    end
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic tick_init();
    rst_n             = 1'b0;
    bus.run_i         = 1'b0;
    bus.step_i        = 1'b0;
    bus.stop_i        = 1'b0;
    bus.icode_i       = 4'h1;
    bus.cnd_i         = 1'b0;
    bus.valC_i        = 64'h0;
    bus.valP_i        = 64'h0;
    bus.valM_i        = 64'h0;
    bus.instr_valid_i = 1'b1;
    bus.imem_error_i  = 1'b0;
    bus.dmem_error_i  = 1'b0;
`ifdef PC_BREAK_EN
    bus.bkpt_en_i     = 1'b0;
    bus.bkpt_addr_i   = 64'h0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask
endmodule
